// File: rtl/y_rr_mux.sv
// y_rr_mux: registered NCH-channel valid/ready selector, fixed-select or round-robin.
// Define Y_RR_MUX_PARITY_EN to add the registered even-parity output out_par.
module y_rr_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef Y_RR_MUX_PARITY_EN
    ,
    output logic                 out_par
`endif
);
    logic             load, gvalid, xfer, rr_found;
    logic [SELW-1:0]  gnt, rr_gnt, c;
    logic [SELW-1:0]  ptr_q, ptr_d, ch_q, ch_d;
    logic [WIDTH-1:0] data_q, data_d, gdata;
    logic             valid_q, valid_d;

    // Round-robin scan starts just after the last granted channel.
    always_comb begin
        rr_gnt   = ptr_q;
        rr_found = 1'b0;
        c        = '0;
        for (int k = 1; k <= NCH; k++) begin
            c = SELW'((int'(ptr_q) + k) % NCH);
            if (!rr_found && in_valid[c]) begin
                rr_gnt   = c;
                rr_found = 1'b1;
            end
        end
    end

    assign load     = !valid_q || out_ready;
    assign gnt      = mode ? rr_gnt : sel;
    assign gvalid   = mode ? |in_valid : (int'(sel) < NCH) && in_valid[sel];
    assign xfer     = load && gvalid;
    assign in_ready = xfer ? NCH'(1) << gnt : '0;
    assign gdata    = in_data[int'(gnt)*WIDTH +: WIDTH];

    always_comb begin
        valid_d = xfer ? 1'b1 : (out_ready ? 1'b0 : valid_q);
        data_d  = xfer ? gdata : data_q;
        ch_d    = xfer ? gnt : ch_q;
        ptr_d   = (xfer && mode) ? gnt : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= SELW'(NCH - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

`ifdef Y_RR_MUX_PARITY_EN
    logic par_q, par_d;
    assign par_d = xfer ? ^gdata : par_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
    assign out_par = par_q;
`endif
endmodule

// File: tb/tb_y_rr_mux.sv
// tb_y_rr_mux: directed and randomized checks of y_rr_mux against a behavioural model.
module tb_y_rr_mux;
    localparam int W    = 32;
    localparam int NCH  = 4;
    localparam int SELW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH*W-1:0]     in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [W-1:0]         out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;
`ifdef Y_RR_MUX_PARITY_EN
    logic                 out_par;
`endif

    y_rr_mux #(.WIDTH(W), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef Y_RR_MUX_PARITY_EN
        , .out_par(out_par)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: the beat held at the output and the last round-robin winner.
    logic                  m_valid;
    logic [W-1:0]          m_data;
    int                    m_ch;
    int                    m_ptr;
    logic [SELW+W-1:0]     sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = NCH - 1;
        sb.delete();
    endtask

    task automatic set_data(input logic [W-1:0] base);
        for (int i = 0; i < NCH; i++) in_data[i*W +: W] = base + W'(i);
    endtask

    // One clock: caller sets inputs right after a negedge; returns at the next negedge.
    task automatic cyc();
        logic ld, gv;
        int g, best, d;
        logic [SELW+W-1:0] front;
        #1;
        ld = !m_valid || out_ready;
        gv = 1'b0;
        g  = 0;
        if (!mode) begin
            if (int'(sel) < NCH && in_valid[sel]) begin
                gv = 1'b1;
                g  = int'(sel);
            end
        end else begin
            best = NCH;
            for (int ch = 0; ch < NCH; ch++)
                if (in_valid[ch]) begin
                    d = (ch - m_ptr - 1 + 2*NCH) % NCH;
                    if (d < best) begin
                        best = d;
                        g    = ch;
                    end
                end
            gv = best < NCH;
        end
        chk("in_ready", 64'(in_ready), (ld && gv) ? 64'(1) << g : 64'(0));
        if (m_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_empty", 64'(sb.size()), 64'(1));
            else begin
                front = sb.pop_front();
                chk("sb_beat", 64'({out_ch, out_data}), 64'(front));
            end
        end
        @(posedge clk);
        #1;
        if (ld && gv) begin
            m_data  = in_data[g*W +: W];
            m_ch    = g;
            m_valid = 1'b1;
            if (mode) m_ptr = g;
            sb.push_back({SELW'(g), m_data});
        end else if (out_ready) m_valid = 1'b0;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_ch", 64'(out_ch), 64'(m_ch));
`ifdef Y_RR_MUX_PARITY_EN
        if (out_valid) chk("out_par", 64'(out_par), 64'(^m_data));
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_ch", 64'(out_ch), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] held_d;
        logic [SELW-1:0] held_c;
        rst_n = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
        set_data(32'h0);
        model_reset();
        do_reset();

        // Fixed select on channel 2, then 3, then channel 3 drops valid.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) in_data[i*W +: W] = 32'hA0 + W'(i);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fix2_data", 64'(out_data), 64'hA2);
            chk("fix2_ch", 64'(out_ch), 64'd2);
            chk("fix2_ready", 64'(in_ready), 64'b0100);
        end
        sel = 2'd3;
        cyc();
        chk("fix3_data", 64'(out_data), 64'hA3);
        in_valid = 4'b0111;
        cyc();
        chk("fix3_idle", 64'(out_valid), 64'd0);

        // Round-robin from reset: all valid, then channels 1 and 3 only.
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_all_ch", 64'(out_ch), 64'(i % NCH));
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_1010_ch", 64'(out_ch), (i % 2 == 0) ? 64'd1 : 64'd3);
        end

        // Back-pressure for five cycles while inputs churn, then release.
        out_ready = 1'b0;
        cyc();
        held_d = out_data;
        held_c = out_ch;
        for (int i = 0; i < 5; i++) begin
            set_data(W'($urandom));
            in_valid = 4'b1111;
            cyc();
            chk("bp_data", 64'(out_data), 64'(held_d));
            chk("bp_ch", 64'(out_ch), 64'(held_c));
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        set_data(32'h5500);
        cyc();
        chk("bp_refill_valid", 64'(out_valid), 64'd1);
        chk("bp_refill_ch", 64'(out_ch), 64'(int'((int'(held_c) + 1) % NCH)));

        // Reset mid-beat, then idle afterwards.
        out_ready = 1'b0;
        cyc();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        do_reset();
        in_valid = '0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_valid", 64'(out_valid), 64'd0);
        end

        // Random soak.
        for (int i = 0; i < 1000; i++) begin
            for (int c = 0; c < NCH; c++) in_data[c*W +: W] = W'($urandom);
            in_valid  = NCH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel       = SELW'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
